mix_columns_iter: RTL and testbench
===================================

Name: mix_columns_iter

Overview:
- Sequential AES forward MixColumns engine. It is the encrypt-side counterpart of the decrypt-path inverse mixing stage.
- Accepts a 128-bit state over a valid/ready handshake and processes COLS_PER_CYCLE 32-bit columns per clock in GF(2^8) (poly 0x11b).
- Returns the result over a second valid/ready handshake.
- Sits between ShiftRows and AddRoundKey in the iterative encrypt round datapath.

Parameters:
- COLS_PER_CYCLE, 1, columns transformed per clock. Legal values: 1, 2, 4. Any other value is an elaboration error.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  in_data valid
- in_ready  output  1  engine can accept a state
- in_data  input  128  state; column c = in_data[127-32c -: 32]; row r of column c = in_data[127-32c-8r -: 8]
- out_valid  output  1  out_data holds a complete result
- out_ready  input  1  downstream accepts the result
- out_data  output  128  result, same byte layout as in_data

Behaviour:
- Column math, per column a0..a3:
  - b0 = 2a0^3a1^a2^a3
  - b1 = a0^2a1^3a2^a3
  - b2 = a0^a1^2a2^3a3
  - b3 = 3a0^a1^a2^2a3
  - 2x = (x<<1) ^ (x[7] ? 8'h1b : 0), truncated to 8 bits; 3x = 2x ^ x.
- Reset is asynchronous. On rst_n low:
  - state = IDLE, column counter = 0, working register = 0.
  - in_ready = 1, out_valid = 0, out_data = 0.
  - Any block in flight is discarded with no output.
- FSM IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: load in_data into the working register, clear the counter, go to BUSY.
- FSM BUSY:
  - in_ready = 0, out_valid = 0.
  - Each clock, columns cnt .. cnt+COLS_PER_CYCLE-1 are replaced in place by their mixed values, and cnt advances by COLS_PER_CYCLE.
  - When the last column is written, go to DONE.
- FSM DONE:
  - out_valid = 1; out_data is the working register, held stable.
  - When out_ready = 1, the result transfers; go to IDLE.
  - out_valid stays high indefinitely while out_ready = 0 (backpressure).
- Latency: handshake accepted at edge N → out_valid high after edge N + 4/COLS_PER_CYCLE.
- Throughput: the earliest next accept is one cycle after the output handshake, because in_ready is high only in IDLE.
- in_valid while not in IDLE is ignored. The upstream holds in_data until accepted.
- out_ready while not in DONE is ignored.
- out_data during BUSY reflects a partially updated register and must not be checked.
- The counter is 2 bits and wraps to 0 on the transition to DONE.

Optional Feature:
- Macro: MIXCOL_INV_EN.
- Defined:
  - Adds input port inv (1 bit), sampled together with in_data on the accept handshake and held for that block.
  - inv = 1 selects inverse coefficients: row 0 = {0e,0b,0d,09}, then rotated per row.
  - 9x, bx, dx, ex are formed from three cascaded xtime stages.
  - inv is reset to 0.
- Undefined:
  - No inv port; forward coefficients only; no inverse multiply logic synthesised.

Decomposition:
- Package aes_mix_pkg holds:
  - xtime function
  - reduction constant 8'h1b
  - FSM state enum {IDLE, BUSY, DONE}
  - forward and inverse coefficient constants
- One natural combinational sub-module: mix_column_word.
  - Ports: 32-bit column in, 32-bit out, inv input present only under MIXCOL_INV_EN.
  - Instantiated COLS_PER_CYCLE times.

Test Plan:
- FIPS-197 vector, COLS_PER_CYCLE=1:
  - in_data = db135345_f20a225c_01010101_c6c6c6c6, out_ready = 1.
  - Expect out_data = 8e4da1bc_9fdc589d_01010101_c6c6c6c6, out_valid exactly 4 cycles after accept, for 1 cycle.
- Vector d4d4d4d5_2d26314c_00000000_ffffffff:
  - Expect d5d5d7d6_4d7ebdf8_00000000_ffffffff.
  - Repeat with COLS_PER_CYCLE=2 and 4: expect 2 and 1 cycle latency, same data.
- Backpressure:
  - Hold out_ready = 0 for 10 cycles after DONE.
  - Expect out_valid and out_data stable and in_ready = 0 throughout; on out_ready = 1, one transfer, then in_ready = 1 the next cycle.
- Reset mid-BUSY:
  - Drop rst_n for 1 cycle after the second column.
  - Expect immediate out_valid = 0, out_data = 0, in_ready = 1 with no spurious output.
  - Next block computes correctly.
- Ignored inputs:
  - Toggle in_valid with different data during BUSY; expect the original result only.
  - Pulse out_ready during IDLE and BUSY; expect no effect.
- MIXCOL_INV_EN defined:
  - inv = 1, in_data = 8e4da1bc_9fdc589d_01010101_c6c6c6c6 → expect db135345_f20a225c_01010101_c6c6c6c6.
  - Back-to-back blocks with inv = 0 then 1 → each block uses its own latched inv.

Source files
------------

// File: rtl/mix_columns_iter_pkg.sv
// rtl/mix_columns_iter_pkg.sv - GF(2^8) helpers, FSM encodings and coefficient constants for AES MixColumns
//
// Package aes_mix_pkg, imported by mix_column_word and mix_columns_iter.
//   GF_POLY          : low byte of the AES field polynomial 0x11b
//   IDLE/BUSY/DONE   : FSM state encodings
//   FWD_COEF         : forward row-0 coefficients {02,03,01,01}
//   INV_COEF         : inverse row-0 coefficients {0e,0b,0d,09}
//   xtime()          : multiply by 2 in GF(2^8)
//   gf_mul()         : multiply by a 4-bit constant using three cascaded xtime stages
package aes_mix_pkg;

  localparam logic [7:0] GF_POLY = 8'h1b;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Byte i (MSB first) is the coefficient applied to a_i for output row 0;
  // later rows use the same bytes rotated right by the row number.
  localparam logic [31:0] FWD_COEF = 32'h02030101;
  localparam logic [31:0] INV_COEF = 32'h0e0b0d09;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? GF_POLY : 8'h00);
  endfunction

  // Every MixColumns coefficient fits in 4 bits, so the product is the XOR of
  // x, 2x, 4x and 8x selected by the coefficient bits. With constant forward
  // coefficients the 4x and 8x terms fold away.
  function automatic logic [7:0] gf_mul(input logic [3:0] c, input logic [7:0] x);
    logic [7:0] x2;
    logic [7:0] x4;
    logic [7:0] x8;
    x2 = xtime(x);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return ({8{c[0]}} & x) ^ ({8{c[1]}} & x2) ^ ({8{c[2]}} & x4) ^ ({8{c[3]}} & x8);
  endfunction

endpackage

// File: rtl/mix_columns_iter_if.sv
// rtl/mix_columns_iter_if.sv - input/output valid-ready bundle for the MixColumns engine
//
// Optional macro MIXCOL_INV_EN adds the inv signal (inverse-mix select).
//   in_valid/in_ready/in_data    : state accepted by the engine
//   out_valid/out_ready/out_data : mixed result returned by the engine
//   master : the upstream/downstream side (drives inputs, takes results)
//   slave  : the engine side
interface mix_columns_iter_if;

  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
`ifdef MIXCOL_INV_EN
  logic         inv;
`endif

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
`ifdef MIXCOL_INV_EN
    , output inv
`endif
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
`ifdef MIXCOL_INV_EN
    , input inv
`endif
  );

endinterface

// File: rtl/mix_columns_iter_mix_column_word.sv
// rtl/mix_columns_iter_mix_column_word.sv - combinational MixColumns on one 32-bit column
//
// Optional macro MIXCOL_INV_EN adds inv_i (1 = inverse coefficients).
//   col_i : column a0..a3, a0 in bits [31:24]
//   inv_i : inverse select (MIXCOL_INV_EN only)
//   col_o : mixed column b0..b3, same layout
module mix_column_word
  import aes_mix_pkg::*;
(
  input  logic [31:0] col_i,
`ifdef MIXCOL_INV_EN
  input  logic        inv_i,
`endif
  output logic [31:0] col_o
);

  logic [3:0] c;

  always_comb begin
    col_o = '0;
    c     = '0;
    for (int r = 0; r < 4; r++) begin
      for (int j = 0; j < 4; j++) begin
        // Coefficient for input byte j in output row r is row-0 byte (j-r) mod 4;
        // only the low nibble of each coefficient byte is ever non-zero.
`ifdef MIXCOL_INV_EN
        c = inv_i ? INV_COEF[27-8*((j-r+4)%4) -: 4] : FWD_COEF[27-8*((j-r+4)%4) -: 4];
`else
        c = FWD_COEF[27-8*((j-r+4)%4) -: 4];
`endif
        col_o[31-8*r -: 8] = col_o[31-8*r -: 8] ^ gf_mul(c, col_i[31-8*j -: 8]);
      end
    end
  end

endmodule

// File: rtl/mix_columns_iter.sv
// rtl/mix_columns_iter.sv - iterative AES MixColumns engine, COLS_PER_CYCLE columns per clock
//
// Optional macro MIXCOL_INV_EN adds a per-block inverse-mix select (bus.inv).
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of mix_columns_iter_if (in_* accept, out_* result)
// Parameter COLS_PER_CYCLE: 1, 2 or 4.
module mix_columns_iter
  import aes_mix_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input logic               clk,
  input logic               rst_n,
  mix_columns_iter_if.slave bus
);

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cfg
    $error("mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  // Step of 4 truncates to 0, so the counter stays at 0 for the single-cycle build.
  localparam logic [1:0] STEP     = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] LAST_CNT = 2'(4 - COLS_PER_CYCLE);

  logic [1:0]   state_q, state_d;
  logic [1:0]   cnt_q, cnt_d;
  logic [127:0] work_q, work_d;
`ifdef MIXCOL_INV_EN
  logic         inv_q, inv_d;
`endif

  logic [1:0]  col_idx [COLS_PER_CYCLE];
  logic [31:0] col_in  [COLS_PER_CYCLE];
  logic [31:0] col_out [COLS_PER_CYCLE];

  for (genvar k = 0; k < COLS_PER_CYCLE; k++) begin : g_col
    assign col_idx[k] = cnt_q + 2'(k);
    assign col_in[k]  = work_q[127-32*col_idx[k] -: 32];

    mix_column_word u_mix (
      .col_i (col_in[k]),
`ifdef MIXCOL_INV_EN
      .inv_i (inv_q),
`endif
      .col_o (col_out[k])
    );
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
`ifdef MIXCOL_INV_EN
    inv_d   = inv_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          work_d  = bus.in_data;
          cnt_d   = '0;
          state_d = BUSY;
`ifdef MIXCOL_INV_EN
          inv_d   = bus.inv;
`endif
        end
      end
      BUSY: begin
        // Columns are mixed in place; each column is read exactly once per block.
        for (int k = 0; k < COLS_PER_CYCLE; k++) begin
          work_d[127-32*col_idx[k] -: 32] = col_out[k];
        end
        cnt_d = cnt_q + STEP;
        if (cnt_q == LAST_CNT) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      work_q  <= '0;
`ifdef MIXCOL_INV_EN
      inv_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
`ifdef MIXCOL_INV_EN
      inv_q   <= inv_d;
`endif
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_data  = work_q;

endmodule

// File: tb/tb_mix_columns_iter.sv
// tb/tb_mix_columns_iter.sv - self-checking bench for mix_columns_iter at COLS_PER_CYCLE 1, 2 and 4
module tb_mix_columns_iter;

  localparam logic [127:0] FIPS_IN  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] FIPS_OUT = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] V2_IN    = 128'hd4d4d4d5_2d26314c_00000000_ffffffff;
  localparam logic [127:0] V2_OUT   = 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff;
  localparam logic [127:0] FWD_M    = 128'h02030101_01020301_01010203_03010102;
  localparam logic [127:0] INV_M    = 128'h0e0b0d09_090e0b0d_0d090e0b_0b0d090e;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic [2:0]   in_valid;
  logic [2:0]   out_ready;
  logic [2:0]   in_ready_s;
  logic [2:0]   out_valid_s;
  logic [127:0] in_data    [3];
  logic [127:0] out_data_s [3];
`ifdef MIXCOL_INV_EN
  logic [2:0]   inv_a;
`endif

  int n_checks = 0;
  int n_err    = 0;

  typedef struct {
    int           d;
    logic [127:0] v;
  } exp_t;
  exp_t sb[$];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mix_columns_iter_if bus ();
    assign bus.in_valid   = in_valid[g];
    assign bus.in_data    = in_data[g];
    assign bus.out_ready  = out_ready[g];
`ifdef MIXCOL_INV_EN
    assign bus.inv        = inv_a[g];
`endif
    assign in_ready_s[g]  = bus.in_ready;
    assign out_valid_s[g] = bus.out_valid;
    assign out_data_s[g]  = bus.out_data;

    mix_columns_iter #(.COLS_PER_CYCLE(1 << g)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
    );
  end

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [127:0] mix_ref(input logic [127:0] s, input bit inv);
    logic [127:0] m;
    logic [127:0] r = '0;
    logic [7:0]   acc;
    m = inv ? INV_M : FWD_M;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++) begin
          acc = acc ^ gmul(m[127-32*row-8*j -: 8], s[127-32*c-8*j -: 8]);
        end
        r[127-32*c-8*row -: 8] = acc;
      end
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int d, input logic [127:0] data, input logic [127:0] exp, input bit push);
    int n = 0;
    in_valid[d] = 1'b1;
    in_data[d]  = data;
    while (in_ready_s[d] !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    chk("accept_wait", 128'(n < 50), 128'(1));
    @(posedge clk);
    #1;
    in_valid[d] = 1'b0;
    in_data[d]  = ~data;
`ifdef MIXCOL_INV_EN
    inv_a[d] = ~inv_a[d];
`endif
    if (push) sb.push_back('{d, exp});
  endtask

  task automatic recv(input int d, input int lat, input int hold);
    int n = 0;
    exp_t e;
    e.d = d;
    e.v = 'x;
    out_ready[d] = (hold == 0);
    while (out_valid_s[d] !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("latency", 128'(n), 128'(lat));
    chk("sb_nonempty", 128'(sb.size() > 0), 128'(1));
    if (sb.size() > 0) e = sb.pop_front();
    chk("out_data", out_data_s[d], e.v);
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("bp_valid", 128'(out_valid_s[d]), 128'(1));
      chk("bp_data", out_data_s[d], e.v);
      chk("bp_in_ready", 128'(in_ready_s[d]), 128'(0));
    end
    out_ready[d] = 1'b1;
    tick();
    chk("post_valid", 128'(out_valid_s[d]), 128'(0));
    chk("post_in_ready", 128'(in_ready_s[d]), 128'(1));
    out_ready[d] = 1'b0;
  endtask

  initial begin
    logic [127:0] data;
    int seen;
    rst_n     = 1'b0;
    in_valid  = '0;
    out_ready = '0;
`ifdef MIXCOL_INV_EN
    inv_a     = '0;
`endif
    for (int d = 0; d < 3; d++) in_data[d] = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      chk("rst_in_ready", 128'(in_ready_s[d]), 128'(1));
      chk("rst_out_valid", 128'(out_valid_s[d]), 128'(0));
      chk("rst_out_data", out_data_s[d], 128'(0));
    end
    rst_n = 1'b1;
    tick();

    send(0, FIPS_IN, FIPS_OUT, 1'b1);
    recv(0, 4, 0);

    for (int d = 0; d < 3; d++) begin
      send(d, V2_IN, V2_OUT, 1'b1);
      recv(d, 4 >> d, 0);
    end

    for (int d = 0; d < 3; d++) begin
      for (int i = 0; i < 3; i++) begin
        data = {$urandom, $urandom, $urandom, $urandom};
        send(d, data, mix_ref(data, 1'b0), 1'b1);
        recv(d, 4 >> d, 0);
      end
    end

    send(0, V2_IN, V2_OUT, 1'b1);
    recv(0, 4, 10);

    out_ready[0] = 1'b1;
    tick();
    chk("idle_oready_in_ready", 128'(in_ready_s[0]), 128'(1));
    chk("idle_oready_valid", 128'(out_valid_s[0]), 128'(0));
    out_ready[0] = 1'b0;
    send(0, FIPS_IN, FIPS_OUT, 1'b1);
    in_valid[0]  = 1'b1;
    in_data[0]   = 128'h0123456789abcdef_fedcba9876543210;
    out_ready[0] = 1'b1;
    tick();
    tick();
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b0;
    recv(0, 2, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ignored_no_output", 128'(out_valid_s[0]), 128'(0));
    end

    send(0, V2_IN, V2_OUT, 1'b0);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 128'(out_valid_s[0]), 128'(0));
    chk("mid_rst_data", out_data_s[0], 128'(0));
    chk("mid_rst_in_ready", 128'(in_ready_s[0]), 128'(1));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (out_valid_s[0] === 1'b1) seen++;
    end
    chk("mid_rst_no_spurious", 128'(seen), 128'(0));
    send(0, FIPS_IN, FIPS_OUT, 1'b1);
    recv(0, 4, 0);

`ifdef MIXCOL_INV_EN
    inv_a[0] = 1'b1;
    send(0, FIPS_OUT, FIPS_IN, 1'b1);
    recv(0, 4, 0);
    inv_a[0] = 1'b0;
    send(0, V2_IN, V2_OUT, 1'b1);
    recv(0, 4, 0);
    inv_a[0] = 1'b1;
    send(0, V2_OUT, V2_IN, 1'b1);
    recv(0, 4, 0);
    for (int d = 1; d < 3; d++) begin
      data = {$urandom, $urandom, $urandom, $urandom};
      inv_a[d] = 1'b1;
      send(d, data, mix_ref(data, 1'b1), 1'b1);
      recv(d, 4 >> d, 0);
    end
`endif

    chk("sb_drained", 128'(sb.size()), 128'(0));
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
